// File: rtl/blake2_pkg.sv
// Shared constants and FSM state type for the BLAKE2s message feeder.
package blake2_pkg;

  localparam int BB     = 64;         // block size in bytes (BLAKE2s only)
  localparam int IDX_W  = 6;          // byte index width within a block
  localparam int LL_W   = 64;         // message length counter width
  localparam int FILL_W = IDX_W + 1;  // fill count must reach BB itself

  typedef enum logic [1:0] {
    FILL = 2'd0,  // collecting upstream bytes into the buffer
    WAIT = 2'd1,  // block closed, waiting for the hash core
    SEND = 2'd2   // streaming 64 bytes (zero padded) to the core
  } feed_state_t;

endpackage

// File: rtl/blake2s_feed_buf.sv
// 64x8 block buffer: one synchronous write port, one combinational read port.
module blake2s_feed_buf
  import blake2_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [BB];

  // Capture accepted bytes at their slot in the block.
  // NOTE: storage is deliberately not reset; unwritten slots are masked to zero by the reader.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/blake2s_msg_feeder.sv
// Byte-stream to block feeder for a BLAKE2s core: buffers up to 64 bytes,
// then streams a full zero-padded block with first/last flags and length.
// Optional feature: define BLAKE2S_FEED_EMPTY_MSG_EN to add s_empty_i for
// zero-length messages. Only BB = 64 is supported.
module blake2s_msg_feeder
  import blake2_pkg::*;
#(
  parameter int BB_UNUSED_GUARD = 0,
  parameter int BB = blake2_pkg::BB
) (
  input  logic             clk,
  input  logic             nreset,        // synchronous, active-high
`ifdef BLAKE2S_FEED_EMPTY_MSG_EN
  input  logic             s_empty_i,
`endif
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  input  logic             ready_v_i,
  output logic             data_v_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic [7:0]       data_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic [LL_W-1:0]  ll_o
);

  feed_state_t       state;
  logic [FILL_W-1:0] fill_cnt;
  logic [LL_W-1:0]   ll_cnt;
  logic              first_armed;   // next closed block starts a message
  logic              empty_take;
  logic              accept;
  logic              close_blk;
  logic [7:0]        rd_byte;

`ifdef BLAKE2S_FEED_EMPTY_MSG_EN
  // An empty-message request only makes sense on a fresh buffer; it wins over a byte.
  assign empty_take = (state == FILL) && (fill_cnt == '0) && s_empty_i;
`else
  assign empty_take = 1'b0;
`endif

  assign s_ready_o = (state == FILL);
  assign accept    = s_valid_i && s_ready_o && !empty_take;
  assign close_blk = accept && (s_last_i || (fill_cnt == FILL_W'(BB - 1)));

  blake2s_feed_buf u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (fill_cnt[IDX_W-1:0]),
    .wdata (s_data_i),
    .raddr (data_idx_o),
    .rdata (rd_byte)
  );

  // Slots beyond the filled count are padding and read as zero.
  assign data_o = (data_v_o && ({1'b0, data_idx_o} < fill_cnt)) ? rd_byte : 8'h00;

  // Feeder FSM with registered block metadata and send strobe/index.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state         <= FILL;
      fill_cnt      <= '0;
      ll_cnt        <= '0;
      first_armed   <= 1'b1;
      data_v_o      <= 1'b0;
      data_idx_o    <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      ll_o          <= '0;
    end else begin
      case (state)
        FILL: begin
          if (empty_take) begin
            state         <= WAIT;
            block_first_o <= 1'b1;
            block_last_o  <= 1'b1;
            ll_o          <= '0;
            ll_cnt        <= '0;
            first_armed   <= 1'b0;
          end else if (accept) begin
            fill_cnt <= fill_cnt + FILL_W'(1);
            ll_cnt   <= ll_cnt + LL_W'(1);
            if (close_blk) begin
              state         <= WAIT;
              block_first_o <= first_armed;
              block_last_o  <= s_last_i;
              ll_o          <= ll_cnt + LL_W'(1);
              first_armed   <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (ready_v_i) begin
            state      <= SEND;
            data_v_o   <= 1'b1;
            data_idx_o <= '0;
          end
        end
        SEND: begin
          if (data_idx_o == IDX_W'(BB - 1)) begin
            state      <= FILL;
            data_v_o   <= 1'b0;
            data_idx_o <= '0;
            fill_cnt   <= '0;
            if (block_last_o) begin
              ll_cnt      <= '0;
              first_armed <= 1'b1;
            end
          end else begin
            data_idx_o <= data_idx_o + IDX_W'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2s_msg_feeder.sv
// Self-checking bench for blake2s_msg_feeder: a block model pushes expected
// beats to a queue as messages are driven; a monitor pops them per data_v_o.
module tb_blake2s_msg_feeder;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        s_valid_i = 1'b0;
  logic [7:0]  s_data_i = 8'h00;
  logic        s_last_i = 1'b0;
  logic        ready_v_i = 1'b1;
  logic        s_ready_o;
  logic        data_v_o;
  logic [5:0]  data_idx_o;
  logic [7:0]  data_o;
  logic        block_first_o;
  logic        block_last_o;
  logic [63:0] ll_o;
`ifdef BLAKE2S_FEED_EMPTY_MSG_EN
  logic        s_empty_i = 1'b0;
`endif

  typedef struct {
    logic [5:0]  idx;
    logic [7:0]  data;
    logic        first;
    logic        last;
    logic [63:0] ll;
  } beat_t;

  typedef logic [7:0] byte_q_t [$];

  beat_t exp_q [$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;

  blake2s_msg_feeder dut (
    .clk           (clk),
    .nreset        (nreset),
`ifdef BLAKE2S_FEED_EMPTY_MSG_EN
    .s_empty_i     (s_empty_i),
`endif
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_last_i      (s_last_i),
    .s_ready_o     (s_ready_o),
    .ready_v_i     (ready_v_i),
    .data_v_o      (data_v_o),
    .data_idx_o    (data_idx_o),
    .data_o        (data_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .ll_o          (ll_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every beat the DUT streams against the next expected beat.
  always @(negedge clk) begin
    if (!nreset && data_v_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {63'd0, data_v_o}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_idx",   {58'd0, data_idx_o},    {58'd0, mon_e.idx});
        check("beat_data",  {56'd0, data_o},        {56'd0, mon_e.data});
        check("beat_first", {63'd0, block_first_o}, {63'd0, mon_e.first});
        check("beat_last",  {63'd0, block_last_o},  {63'd0, mon_e.last});
        check("beat_ll",    ll_o,                   mon_e.ll);
      end
    end
  end

  // Model: split a message into 64-byte blocks and queue the padded beats.
  task automatic push_msg(input byte_q_t msg);
    int   n = msg.size();
    int   pos = 0;
    logic first = 1'b1;
    while (pos < n) begin
      int   len = ((n - pos) > 64) ? 64 : (n - pos);
      logic last = ((pos + len) == n);
      for (int i = 0; i < 64; i++) begin
        beat_t b;
        b.idx   = 6'(i);
        b.data  = (i < len) ? msg[pos + i] : 8'h00;
        b.first = first;
        b.last  = last;
        b.ll    = 64'(pos + len);
        exp_q.push_back(b);
      end
      first = 1'b0;
      pos  += len;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    @(negedge clk);
    while (!s_ready_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready_o) check("ready_timeout", {63'd0, s_ready_o}, 64'd1);
    s_valid_i = 1'b1;
    s_data_i  = b;
    s_last_i  = last;
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg);
    for (int i = 0; i < msg.size(); i++) send_byte(msg[i], i == msg.size() - 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || data_v_o) && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t msg;
    int      t;

    // Reset state: outputs zero except s_ready_o.
    repeat (3) @(negedge clk);
    check("rst_s_ready",  {63'd0, s_ready_o},     64'd1);
    check("rst_data_v",   {63'd0, data_v_o},      64'd0);
    check("rst_data_idx", {58'd0, data_idx_o},    64'd0);
    check("rst_data",     {56'd0, data_o},        64'd0);
    check("rst_first",    {63'd0, block_first_o}, 64'd0);
    check("rst_last",     {63'd0, block_last_o},  64'd0);
    check("rst_ll",       ll_o,                   64'd0);
    nreset = 1'b0;

    // "abc" with a two-cycle latency check from the closing byte.
    msg = '{8'h61, 8'h62, 8'h63};
    push_msg(msg);
    send_msg(msg);
    check("abc_s_ready_wait", {63'd0, s_ready_o}, 64'd0);
    @(negedge clk);
    check("abc_lat_wait", {63'd0, data_v_o}, 64'd0);
    @(negedge clk);
    check("abc_lat_send", {63'd0, data_v_o}, 64'd1);
    wait_drain();

    // Exactly 64 bytes closed by last: a single full last block.
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i));
    push_msg(msg);
    send_msg(msg);
    wait_drain();
    check("full64_no_extra", {63'd0, data_v_o}, 64'd0);

    // 65 bytes: full non-last block then a one-byte last block.
    msg.delete();
    for (int i = 0; i < 65; i++) msg.push_back(8'(i) ^ 8'h5A);
    push_msg(msg);
    send_msg(msg);
    wait_drain();

    // 130 random bytes spanning three blocks.
    msg.delete();
    for (int i = 0; i < 130; i++) msg.push_back(8'($urandom_range(0, 255)));
    push_msg(msg);
    send_msg(msg);
    wait_drain();

    // Core not ready: hold in WAIT for 20 cycles, then release.
    ready_v_i = 1'b0;
    msg = '{8'hA5, 8'h3C};
    push_msg(msg);
    send_msg(msg);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_s_ready", {63'd0, s_ready_o}, 64'd0);
      check("hold_data_v",  {63'd0, data_v_o},  64'd0);
    end
    ready_v_i = 1'b1;
    @(negedge clk);
    check("release_data_v",  {63'd0, data_v_o},   64'd1);
    check("release_idx0",    {58'd0, data_idx_o}, 64'd0);
    wait_drain();

    // Reset in the middle of SEND aborts the block.
    msg = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push_msg(msg);
    send_msg(msg);
    t = 0;
    while (!(data_v_o && data_idx_o == 6'd30) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort_idx30_reached", {58'd0, data_idx_o}, 64'd30);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("abort_data_v",  {63'd0, data_v_o},      64'd0);
    check("abort_idx",     {58'd0, data_idx_o},    64'd0);
    check("abort_first",   {63'd0, block_first_o}, 64'd0);
    check("abort_ll",      ll_o,                   64'd0);
    check("abort_s_ready", {63'd0, s_ready_o},     64'd1);
    nreset = 1'b0;
    msg = '{8'h7E};
    push_msg(msg);
    send_msg(msg);
    wait_drain();

`ifdef BLAKE2S_FEED_EMPTY_MSG_EN
    // Empty message: s_empty_i beats a simultaneous byte, 64 zero bytes follow.
    for (int i = 0; i < 64; i++) begin
      beat_t b;
      b.idx = 6'(i); b.data = 8'h00; b.first = 1'b1; b.last = 1'b1; b.ll = 64'd0;
      exp_q.push_back(b);
    end
    @(negedge clk);
    s_empty_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 8'hFF;
    s_last_i  = 1'b1;
    @(posedge clk);
    #1;
    s_empty_i = 1'b0;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    wait_drain();
    msg = '{8'h42};
    push_msg(msg);
    send_msg(msg);
    wait_drain();
`endif

    repeat (3) @(negedge clk);
    check("final_idle_data_v", {63'd0, data_v_o}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
